// File: rtl/intr_svc_pkg.sv
// intr_svc_pkg: shared types and widths for the interrupt-service initiator.
//   svc_state_e : FSM state encoding (RD_* states exist only when
//                 INTR_SVC_READBACK_VERIFY_EN is defined).
//   ADDR_W/DATA_W : bus address/data widths, PRIO_W : priority field width,
//   CNT_W : service counter width, IDX_W : interrupt index width.
package intr_svc_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int PRIO_W = 4;
  localparam int CNT_W  = 16;
  localparam int IDX_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_GAP,
    ST_SVC_WAIT,
    ST_SVC_HOLD,
    ST_SVC_ACK
`ifdef INTR_SVC_READBACK_VERIFY_EN
    ,
    ST_RD_REQ,
    ST_RD_GAP
`endif
  } svc_state_e;

endpackage

// File: rtl/intr_svc_initiator_if.sv
// intr_svc_initiator_if: APB-style register bus between the initiator
// (master) and the priority interrupt controller (slave).
//   paddr_o/pwdata_o/pwrite_o/penable_o : request, driven by the master.
//   prdata_i/pready_i/perror_i          : response, driven by the slave.
// Handshake: the master raises penable_o with address/data/direction and
// holds them unchanged until it samples pready_i=1 on a rising clock edge;
// that edge completes the transfer, and perror_i/prdata_i are meaningful
// only on that same edge.
interface intr_svc_initiator_if;
  import intr_svc_pkg::*;

  logic [ADDR_W-1:0] paddr_o;
  logic [DATA_W-1:0] pwdata_o;
  logic              pwrite_o;
  logic              penable_o;
  logic [DATA_W-1:0] prdata_i;
  logic              pready_i;
  logic              perror_i;

  modport master (
    output paddr_o, pwdata_o, pwrite_o, penable_o,
    input  prdata_i, pready_i, perror_i
  );

  modport slave (
    input  paddr_o, pwdata_o, pwrite_o, penable_o,
    output prdata_i, pready_i, perror_i
  );

endinterface

// File: rtl/intr_svc_apb_xfer.sv
// intr_svc_apb_xfer: single-transfer bus engine used for writes and reads.
//   clk_i, rst_i          : clock, async active-high reset.
//   go_i                  : launch a transfer (only while idle).
//   addr_i/wdata_i/write_i: request captured on the launch edge.
//   bus_if (master)       : registered request outputs, response inputs.
//   done_o                : this edge completes the transfer (pready seen).
//   xerr_o                : completion with perror_i set.
//   timeout_o             : PREADY_TIMEOUT cycles passed without pready_i;
//                           the bus is dropped on this edge.
module intr_svc_apb_xfer import intr_svc_pkg::*; #(
  parameter int PREADY_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              go_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              write_i,
  intr_svc_initiator_if.master bus_if,
  output logic              done_o,
  output logic              xerr_o,
  output logic              timeout_o
);

  localparam int TMO_W = $clog2(PREADY_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PREADY_TIMEOUT - 1);

  logic              busy_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              pwrite_q;
  logic              penable_q;

  assign done_o    = busy_q & bus_if.pready_i;
  assign xerr_o    = done_o & bus_if.perror_i;
  // The cycle that would make the wait PREADY_TIMEOUT long is the last one.
  assign timeout_o = busy_q & ~bus_if.pready_i & (tmo_q == TMO_LAST);

  assign bus_if.paddr_o   = paddr_q;
  assign bus_if.pwdata_o  = pwdata_q;
  assign bus_if.pwrite_o  = pwrite_q;
  assign bus_if.penable_o = penable_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q    <= 1'b0;
      tmo_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
    end else if (go_i) begin
      busy_q    <= 1'b1;
      tmo_q     <= '0;
      paddr_q   <= addr_i;
      pwdata_q  <= wdata_i;
      pwrite_q  <= write_i;
      penable_q <= 1'b1;
    end else if (done_o || timeout_o) begin
      busy_q    <= 1'b0;
      tmo_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
    end else if (busy_q) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

endmodule

// File: rtl/intr_svc_initiator.sv
// intr_svc_initiator: programs NUM_INTR priority registers of the interrupt
// controller, then services interrupts (hold SVC_CYCLES, clear, acknowledge).
// Optional macro INTR_SVC_READBACK_VERIFY_EN adds a verifying read after
// every write.
//   pclk_i, prst_i        : clock, async active-high reset.
//   start_i               : begin (re)programming from index 0.
//   prio_tbl_i            : priority of source k at [4k+3:4k].
//   bus_if (master)       : register write/read bus.
//   intr_to_service_i     : index of the pending interrupt.
//   intr_valid_i          : controller has a pending interrupt.
//   intr_serviced_o       : one-cycle service acknowledge.
//   intr_clear_o          : one-hot one-cycle clear of the serviced source.
//   cfg_done_o            : programming complete, service loop active.
//   err_o                 : sticky bus error / timeout.
//   svc_count_o           : completed services (wraps).
//   dbg_state_o           : current FSM state.
module intr_svc_initiator import intr_svc_pkg::*; #(
  parameter int NUM_INTR       = 16,
  parameter int SVC_CYCLES     = 2,
  parameter int PREADY_TIMEOUT = 16
) (
  input  logic                       pclk_i,
  input  logic                       prst_i,
  input  logic                       start_i,
  input  logic [PRIO_W*NUM_INTR-1:0] prio_tbl_i,
  intr_svc_initiator_if.master       bus_if,
  input  logic [IDX_W-1:0]           intr_to_service_i,
  input  logic                       intr_valid_i,
  output logic                       intr_serviced_o,
  output logic [NUM_INTR-1:0]        intr_clear_o,
  output logic                       cfg_done_o,
  output logic                       err_o,
  output logic [CNT_W-1:0]           svc_count_o,
  output svc_state_e                 dbg_state_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INTR - 1);
  localparam int HOLD_W = $clog2(SVC_CYCLES + 1);

  svc_state_e          state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    svc_idx_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                cfg_done_q;
  logic                err_q;
  logic                serviced_q;
  logic [NUM_INTR-1:0] clear_q;
  logic [CNT_W-1:0]    svc_count_q;
`ifdef INTR_SVC_READBACK_VERIFY_EN
  logic [PRIO_W-1:0]   wr_prio_q;
`endif

  // Transfer launch decision, taken in the same cycle the FSM leaves
  // IDLE / a gap / SVC_WAIT so the request appears registered next cycle.
  logic              go_d;
  logic              go_write_d;
  logic [IDX_W-1:0]  go_idx_d;
  logic [PRIO_W-1:0] go_prio_d;
  logic [DATA_W-1:0] go_wdata_d;
  logic [ADDR_W-1:0] go_addr_d;
  logic              x_done, x_err, x_tmo;
  logic [NUM_INTR-1:0] clear_vec;

  always_comb begin
    go_d       = 1'b0;
    go_write_d = 1'b1;
    go_idx_d   = idx_q;
    case (state_q)
      ST_IDLE, ST_SVC_WAIT: begin
        if (start_i) begin
          go_d     = 1'b1;
          go_idx_d = '0;
        end
      end
`ifdef INTR_SVC_READBACK_VERIFY_EN
      ST_WR_GAP: begin
        go_d       = 1'b1;
        go_write_d = 1'b0;
      end
      ST_RD_GAP: begin
        if (idx_q < LAST_IDX) begin
          go_d     = 1'b1;
          go_idx_d = idx_q + 1'b1;
        end
      end
`else
      ST_WR_GAP: begin
        if (idx_q < LAST_IDX) begin
          go_d     = 1'b1;
          go_idx_d = idx_q + 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  assign go_prio_d  = prio_tbl_i[PRIO_W*int'(go_idx_d) +: PRIO_W];
  assign go_wdata_d = go_write_d ? {{(DATA_W-PRIO_W){1'b0}}, go_prio_d} : '0;
  assign go_addr_d  = {{(ADDR_W-IDX_W){1'b0}}, go_idx_d};

  // Indices at or above NUM_INTR match no bit and clear nothing.
  always_comb begin
    clear_vec = '0;
    for (int k = 0; k < NUM_INTR; k++) clear_vec[k] = (int'(svc_idx_q) == k);
  end

  intr_svc_apb_xfer #(.PREADY_TIMEOUT(PREADY_TIMEOUT)) u_xfer (
    .clk_i     (pclk_i),
    .rst_i     (prst_i),
    .go_i      (go_d),
    .addr_i    (go_addr_d),
    .wdata_i   (go_wdata_d),
    .write_i   (go_write_d),
    .bus_if    (bus_if),
    .done_o    (x_done),
    .xerr_o    (x_err),
    .timeout_o (x_tmo)
  );

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      svc_idx_q   <= '0;
      hold_q      <= '0;
      cfg_done_q  <= 1'b0;
      err_q       <= 1'b0;
      serviced_q  <= 1'b0;
      clear_q     <= '0;
      svc_count_q <= '0;
`ifdef INTR_SVC_READBACK_VERIFY_EN
      wr_prio_q   <= '0;
`endif
    end else begin
      serviced_q <= 1'b0;
      clear_q    <= '0;
      if (go_d) idx_q <= go_idx_d;
`ifdef INTR_SVC_READBACK_VERIFY_EN
      if (go_d && go_write_d) wr_prio_q <= go_prio_d;
`endif
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            err_q   <= 1'b0;
            state_q <= ST_WR_REQ;
          end
        end
        ST_WR_REQ: begin
          if (x_tmo) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else if (x_done) begin
            if (x_err) err_q <= 1'b1;
            state_q <= ST_WR_GAP;
          end
        end
`ifdef INTR_SVC_READBACK_VERIFY_EN
        ST_WR_GAP: state_q <= ST_RD_REQ;
        ST_RD_REQ: begin
          if (x_tmo) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else if (x_done) begin
            if (x_err || (bus_if.prdata_i[PRIO_W-1:0] != wr_prio_q)) err_q <= 1'b1;
            state_q <= ST_RD_GAP;
          end
        end
        ST_RD_GAP: begin
`else
        ST_WR_GAP: begin
`endif
          if (idx_q < LAST_IDX) begin
            state_q <= ST_WR_REQ;
          end else begin
            cfg_done_q <= 1'b1;
            state_q    <= ST_SVC_WAIT;
          end
        end
        ST_SVC_WAIT: begin
          if (start_i) begin
            cfg_done_q <= 1'b0;
            err_q      <= 1'b0;
            state_q    <= ST_WR_REQ;
          end else if (intr_valid_i) begin
            svc_idx_q <= intr_to_service_i;
            hold_q    <= HOLD_W'(SVC_CYCLES);
            state_q   <= ST_SVC_HOLD;
          end
        end
        ST_SVC_HOLD: begin
          if (!intr_valid_i) begin
            state_q <= ST_SVC_WAIT;
          end else if (hold_q == '0) begin
            serviced_q  <= 1'b1;
            clear_q     <= clear_vec;
            svc_count_q <= svc_count_q + 1'b1;
            state_q     <= ST_SVC_ACK;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        ST_SVC_ACK: state_q <= ST_SVC_WAIT;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign intr_serviced_o = serviced_q;
  assign intr_clear_o    = clear_q;
  assign cfg_done_o      = cfg_done_q;
  assign err_o           = err_q;
  assign svc_count_o     = svc_count_q;
  assign dbg_state_o     = state_q;

endmodule
